// File: rtl/shift_arbiter.sv
// Two-requester round-robin front end for a single shared 32-bit barrel shifter.
// One registered response slot carries the result, the winning requester id and its tag.

module barrel_shifter (
    input  logic [31:0] i_data,
    input  logic [4:0]  i_shamt,
    input  logic        i_left,
    input  logic        i_arith,
    output logic [31:0] o_data
);

    logic        fill;
    logic [31:0] stg_in;
    logic [31:0] stg_p0;
    logic [31:0] stg_p1;
    logic [31:0] stg_p2;
    logic [31:0] stg_p3;
    logic [31:0] stg_p4;

    // Left shifts reuse the right-shift network by mirroring the word on entry and exit.
    function automatic logic [31:0] bit_reverse(input logic [31:0] value);
        logic [31:0] rev;
        for (int i = 0; i < 32; i++) begin
            rev[i] = value[31-i];
        end
        return rev;
    endfunction

    always_comb begin
        fill   = i_arith && !i_left && i_data[31];
        stg_in = i_left ? bit_reverse(i_data) : i_data;
        stg_p0 = i_shamt[0] ? {fill, stg_in[31:1]}          : stg_in;
        stg_p1 = i_shamt[1] ? {{2{fill}},  stg_p0[31:2]}    : stg_p0;
        stg_p2 = i_shamt[2] ? {{4{fill}},  stg_p1[31:4]}    : stg_p1;
        stg_p3 = i_shamt[3] ? {{8{fill}},  stg_p2[31:8]}    : stg_p2;
        stg_p4 = i_shamt[4] ? {{16{fill}}, stg_p3[31:16]}   : stg_p3;
        o_data = i_left ? bit_reverse(stg_p4) : stg_p4;
    end

endmodule

module shift_arbiter #(
    parameter int TAG_W = 5
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_req0_valid,
    output logic             o_req0_ready,
    input  logic [31:0]      i_req0_op_a,
    input  logic [31:0]      i_req0_op_b,
    input  logic [1:0]       i_req0_op,
    input  logic [TAG_W-1:0] i_req0_tag,
    input  logic             i_req1_valid,
    output logic             o_req1_ready,
    input  logic [31:0]      i_req1_op_a,
    input  logic [31:0]      i_req1_op_b,
    input  logic [1:0]       i_req1_op,
    input  logic [TAG_W-1:0] i_req1_tag,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [31:0]      o_rsp_data,
    output logic             o_rsp_id,
    output logic [TAG_W-1:0] o_rsp_tag
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_data_q,  rsp_data_d;
    logic             rsp_id_q,    rsp_id_d;
    logic [TAG_W-1:0] rsp_tag_q,   rsp_tag_d;
    logic             rr_q,        rr_d;

    logic             can_accept;
    logic             gnt0;
    logic             gnt1;
    logic             gnt_id;
    logic             accept;

    logic [31:0]      mux_op_a;
    logic [4:0]       mux_shamt;
    logic [1:0]       mux_op;
    logic [TAG_W-1:0] mux_tag;
    logic [31:0]      shift_out;
    logic [31:0]      result;

    // Only the low five bits of each shift amount reach the shifter.
    logic             unused_op_b_hi;
    assign unused_op_b_hi = ^{i_req0_op_b[31:5], i_req1_op_b[31:5]};

    // Reserved op code 11 returns zero rather than a shifted value.
    function automatic logic [31:0] select_result(input logic [1:0] op, input logic [31:0] shifted);
        logic [31:0] res;
        case (op)
            OP_SLL:  res = shifted;
            OP_SRL:  res = shifted;
            OP_SRA:  res = shifted;
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    always_comb begin
        can_accept = !rsp_valid_q || i_rsp_ready;
        gnt0       = i_req0_valid && (!i_req1_valid || !rr_q);
        gnt1       = i_req1_valid && (!i_req0_valid ||  rr_q);
        gnt_id     = gnt1;
        accept     = can_accept && (gnt0 || gnt1) && !i_reset;
    end

    assign o_req0_ready = can_accept && gnt0 && !i_reset;
    assign o_req1_ready = can_accept && gnt1 && !i_reset;

    always_comb begin
        mux_op_a  = gnt_id ? i_req1_op_a      : i_req0_op_a;
        mux_shamt = gnt_id ? i_req1_op_b[4:0] : i_req0_op_b[4:0];
        mux_op    = gnt_id ? i_req1_op        : i_req0_op;
        mux_tag   = gnt_id ? i_req1_tag       : i_req0_tag;
    end

    barrel_shifter u_shifter (
        .i_data  (mux_op_a),
        .i_shamt (mux_shamt),
        .i_left  (mux_op == OP_SLL),
        .i_arith (mux_op == OP_SRA),
        .o_data  (shift_out)
    );

    assign result = select_result(mux_op, shift_out);

    // Accept has priority over drain so a back-to-back stream keeps valid high.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        rsp_tag_d   = rsp_tag_q;
        rr_d        = rr_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = result;
            rsp_id_d    = gnt_id;
            rsp_tag_d   = mux_tag;
            rr_d        = !gnt_id;
        end else if (i_rsp_ready && rsp_valid_q) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Response stage register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
            rsp_tag_q   <= '0;
            rr_q        <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            rsp_tag_q   <= rsp_tag_d;
            rr_q        <= rr_d;
        end
    end

    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_id    = rsp_id_q;
    assign o_rsp_tag   = rsp_tag_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level reference model.

module tb_shift_arbiter;

    localparam int TAG_W = 5;

    typedef struct packed {
        logic             valid;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [1:0]       op;
        logic [TAG_W-1:0] tag;
    } req_t;

    logic             clk = 1'b0;
    logic             i_reset;
    logic             i_req0_valid, i_req1_valid;
    logic             o_req0_ready, o_req1_ready;
    logic [31:0]      i_req0_op_a, i_req0_op_b, i_req1_op_a, i_req1_op_b;
    logic [1:0]       i_req0_op, i_req1_op;
    logic [TAG_W-1:0] i_req0_tag, i_req1_tag;
    logic             o_rsp_valid, i_rsp_ready, o_rsp_id;
    logic [31:0]      o_rsp_data;
    logic [TAG_W-1:0] o_rsp_tag;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic             m_valid, m_id, m_rr;
    logic [31:0]      m_data;
    logic [TAG_W-1:0] m_tag;
    logic             acc0, acc1, obs_r0, obs_r1;

    always #5 clk = ~clk;

    shift_arbiter #(.TAG_W(TAG_W)) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_req0_valid (i_req0_valid),
        .o_req0_ready (o_req0_ready),
        .i_req0_op_a  (i_req0_op_a),
        .i_req0_op_b  (i_req0_op_b),
        .i_req0_op    (i_req0_op),
        .i_req0_tag   (i_req0_tag),
        .i_req1_valid (i_req1_valid),
        .o_req1_ready (o_req1_ready),
        .i_req1_op_a  (i_req1_op_a),
        .i_req1_op_b  (i_req1_op_b),
        .i_req1_op    (i_req1_op),
        .i_req1_tag   (i_req1_tag),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_data   (o_rsp_data),
        .o_rsp_id     (o_rsp_id),
        .o_rsp_tag    (o_rsp_tag)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [31:0] b,
                                              input logic [1:0] op);
        int sh;
        sh = int'(b % 32);
        case (op)
            2'd0:    return a << sh;
            2'd1:    return a >> sh;
            2'd2:    return $unsigned($signed(a) >>> sh);
            default: return 32'h0;
        endcase
    endfunction

    function automatic req_t mk(input logic v, input logic [31:0] a, input logic [31:0] b,
                                input logic [1:0] op, input logic [TAG_W-1:0] tag);
        req_t r;
        r.valid = v; r.a = a; r.b = b; r.op = op; r.tag = tag;
        return r;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.valid = ($urandom_range(3) != 0);
        r.a     = $urandom;
        r.b     = ($urandom_range(1) != 0) ? $urandom : 32'($urandom_range(40));
        r.op    = 2'($urandom_range(3));
        r.tag   = TAG_W'($urandom);
        return r;
    endfunction

    // One clock cycle: drive, compare at the falling edge, advance the model.
    task automatic step(input logic rst, input req_t r0, input req_t r1, input logic rdy);
        logic can, win, e0, e1;
        req_t w;
        i_reset      = rst;
        i_req0_valid = r0.valid; i_req0_op_a = r0.a; i_req0_op_b = r0.b;
        i_req0_op    = r0.op;    i_req0_tag  = r0.tag;
        i_req1_valid = r1.valid; i_req1_op_a = r1.a; i_req1_op_b = r1.b;
        i_req1_op    = r1.op;    i_req1_tag  = r1.tag;
        i_rsp_ready  = rdy;
        @(negedge clk);
        can = !m_valid || rdy;
        win = (r0.valid && r1.valid) ? m_rr : r1.valid;
        e0  = !rst && can && r0.valid && !win;
        e1  = !rst && can && r1.valid &&  win;
        obs_r0 = o_req0_ready;
        obs_r1 = o_req1_ready;
        check("req0_ready", 64'(o_req0_ready), 64'(e0));
        check("req1_ready", 64'(o_req1_ready), 64'(e1));
        check("rsp_valid",  64'(o_rsp_valid),  64'(m_valid));
        check("rsp_data",   64'(o_rsp_data),   64'(m_data));
        check("rsp_id",     64'(o_rsp_id),     64'(m_id));
        check("rsp_tag",    64'(o_rsp_tag),    64'(m_tag));
        if (rst) begin
            m_valid = 0; m_data = 0; m_id = 0; m_tag = 0; m_rr = 0;
        end else if (e0 || e1) begin
            w       = win ? r1 : r0;
            m_valid = 1;
            m_data  = ref_shift(w.a, w.b, w.op);
            m_id    = win;
            m_tag   = w.tag;
            m_rr    = !win;
        end else if (rdy && m_valid) begin
            m_valid = 0;
        end
        acc0 = e0;
        acc1 = e1;
        @(posedge clk);
        #1;
    endtask

    req_t idle, p0, p1;
    logic [31:0] saved_data;
    logic        saved_id;
    logic [TAG_W-1:0] saved_tag;

    initial begin
        idle = mk(0, 0, 0, 0, 0);
        i_reset = 1; i_rsp_ready = 0;
        i_req0_valid = 0; i_req0_op_a = 0; i_req0_op_b = 0; i_req0_op = 0; i_req0_tag = 0;
        i_req1_valid = 0; i_req1_op_a = 0; i_req1_op_b = 0; i_req1_op = 0; i_req1_tag = 0;
        repeat (2) @(posedge clk);
        #1;
        m_valid = 0; m_data = 0; m_id = 0; m_tag = 0; m_rr = 0; acc0 = 0; acc1 = 0;

        // Reset held with both requesters asking, then requester 0 wins first.
        repeat (2) step(1, mk(1, 32'h5, 32'h1, 0, 1), mk(1, 32'h6, 32'h2, 1, 2), 1);
        step(0, mk(1, 32'h5, 32'h1, 0, 1), mk(1, 32'h6, 32'h2, 1, 2), 1);
        check("post_reset_grant0", 64'(obs_r0), 64'd1);
        step(0, idle, idle, 1);

        step(0, mk(1, 32'h1, 32'h1F, 2'b00, 5'd3), idle, 1);
        check("sll31_data",  64'(o_rsp_data),  64'h8000_0000);
        check("sll31_id",    64'(o_rsp_id),    64'd0);
        check("sll31_tag",   64'(o_rsp_tag),   64'd3);
        check("sll31_valid", 64'(o_rsp_valid), 64'd1);

        step(0, idle, mk(1, 32'h8000_0000, 32'h24, 2'b10, 5'd7), 1);
        check("sra_hi_data", 64'(o_rsp_data), 64'hF800_0000);
        check("sra_hi_id",   64'(o_rsp_id),   64'd1);
        step(0, idle, mk(1, 32'h8000_0000, 32'h24, 2'b01, 5'd7), 1);
        check("srl_hi_data", 64'(o_rsp_data), 64'h0800_0000);
        step(0, idle, mk(1, 32'h8000_0000, 32'h24, 2'b11, 5'd7), 1);
        check("rsvd_data",   64'(o_rsp_data), 64'h0);

        // Contention from a fresh pointer alternates 0,1,0,1,...
        step(1, idle, idle, 1);
        for (int i = 0; i < 6; i++) begin
            step(0, mk(1, $urandom, $urandom, 2'($urandom_range(3)), 5'(i)),
                    mk(1, $urandom, $urandom, 2'($urandom_range(3)), 5'(i + 16)), 1);
            check("contend_id", 64'(o_rsp_id), 64'(i % 2));
        end

        // Backpressure with both requesters waiting, then drain and accept in one edge.
        saved_data = o_rsp_data; saved_id = o_rsp_id; saved_tag = o_rsp_tag;
        p0 = mk(1, 32'hF0F0_0001, 32'h3, 2'b10, 5'd9);
        p1 = mk(1, 32'h0000_FFFF, 32'h8, 2'b00, 5'd10);
        for (int i = 0; i < 3; i++) begin
            step(0, p0, p1, 0);
            check("bp_no_ready", 64'({obs_r0, obs_r1}), 64'd0);
            check("bp_data",     64'(o_rsp_data), 64'(saved_data));
            check("bp_id_tag",   64'({o_rsp_id, o_rsp_tag}), 64'({saved_id, saved_tag}));
        end
        step(0, p0, p1, 1);
        check("bp_release_valid", 64'(o_rsp_valid), 64'd1);
        check("bp_release_accept", 64'(obs_r0 | obs_r1), 64'd1);

        // Reset with a pending response and pointer favouring requester 1.
        step(0, mk(1, 32'h1234_5678, 32'h4, 2'b01, 5'd5), idle, 1);
        check("mid_pre_valid", 64'(o_rsp_valid), 64'd1);
        step(1, p0, p1, 0);
        check("mid_rst_valid", 64'(o_rsp_valid), 64'd0);
        check("mid_rst_data",  64'(o_rsp_data),  64'd0);
        step(0, p0, p1, 1);
        check("mid_rst_grant0", 64'(obs_r0), 64'd1);
        check("mid_rst_id",     64'(o_rsp_id), 64'd0);

        // Random traffic; pending requests are held until accepted.
        p0 = idle; p1 = idle;
        for (int c = 0; c < 600; c++) begin
            if (!(p0.valid && !acc0) || acc0) p0 = rand_req();
            if (!(p1.valid && !acc1) || acc1) p1 = rand_req();
            step(($urandom_range(63) == 0), p0, p1, ($urandom_range(3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Shares one combinational `barrel_shifter` between two requesters, for example the EX-stage ALU and a multi-cycle unit. It uses round-robin arbitration and a valid/ready handshake on every side. A single registered response stage holds one result, tagged with the winning requester and its tag. The block sits in EX and the response feeds the EX/MEM boundary.

## Interface
Parameters:
- TAG_W, default 5: width of the requester tag carried through unchanged (e.g. rd index).

Ports:
- i_clk  in  1  clock; all state updates on the rising edge
- i_reset  in  1  synchronous, active-high reset
- i_req0_valid  in  1  requester 0 has a shift request
- o_req0_ready  out  1  requester 0 request accepted this cycle (when valid)
- i_req0_op_a  in  32  value to shift
- i_req0_op_b  in  32  shift amount; only [4:0] used
- i_req0_op  in  2  shift operation: 00 SLL, 01 SRL, 10 SRA, 11 reserved
- i_req0_tag  in  TAG_W  opaque tag
- i_req1_valid, o_req1_ready, i_req1_op_a, i_req1_op_b, i_req1_op, i_req1_tag  same as requester 0, for requester 1
- o_rsp_valid  out  1  response register holds a result
- i_rsp_ready  in  1  consumer takes the response this cycle
- o_rsp_data  out  32  shifted result
- o_rsp_id  out  1  winning requester (0 or 1)
- o_rsp_tag  out  TAG_W  tag of the winning request

## Operation
- **Single shared shifter.** One `barrel_shifter` instance. Its inputs are muxed from the granted requester. Its result is selected by the granted op:
  - 00 → SLL
  - 01 → SRL
  - 10 → SRA
  - 11 → 0x0000_0000
- **Accept condition:** `can_accept = !o_rsp_valid || i_rsp_ready`.
- **Grant:**
  - Only one requester valid: that requester is granted.
  - Both valid: the requester selected by the round-robin pointer `rr` is granted.
  - `o_reqN_ready = can_accept && grantN`.
  - Ready is never asserted to a non-valid requester, and never to both requesters in one cycle.
- **Round-robin pointer** (1 bit):
  - On every accepted request, `rr` is set to the index of the loser (the non-granted requester).
  - If no request is accepted, `rr` is unchanged.
  - Consequence: under continuous contention, a waiting requester is granted within 1 accepted transfer.
- **Response register, on an accept:** loads data, id and tag and sets `o_rsp_valid`.
- **Response register, no accept:**
  - If `i_rsp_ready && o_rsp_valid`: clears `o_rsp_valid`.
  - Otherwise holds.
- **Simultaneous drain and accept:** the old response leaves and the new one loads in the same cycle, so `o_rsp_valid` stays 1.
- **Backpressure:** while `o_rsp_valid && !i_rsp_ready`:
  - `o_rsp_data`, `o_rsp_id` and `o_rsp_tag` stay stable.
  - Both readies are 0.
- **Request side:** requesters must hold their request fields stable while valid and not ready. The block does not check this.
- **Width rules:**
  - Shift amount is `op_b[4:0]` only; `op_b[31:5]` is ignored (e.g. 0x24 shifts by 4).
  - SRA fills with `op_a[31]`.
  - SLL and SRL fill with zeros.

## Timing
- **Reset (i_reset=1 at a rising edge):**
  - `o_rsp_valid`=0, `o_rsp_data`=0, `o_rsp_id`=0, `o_rsp_tag`=0, `rr`=0 (requester 0 favoured).
  - While i_reset=1, `o_req0_ready` and `o_req1_ready` are forced to 0.
  - Reset overrides any pending response or accept in the same cycle.
- **Latency:** 1 cycle. A request accepted at edge N appears on `o_rsp_*` after edge N, valid in cycle N+1.
- **Throughput:** 1 result per cycle when `i_rsp_ready`=1.
- **Combinational paths:**
  - `o_reqN_ready` depends combinationally on both `i_reqN_valid`, on `i_rsp_ready` and on state.
  - `o_rsp_*` are register outputs only.
- **Critical path:** request mux → shifter (5 stages) → op mux → response register.

## Test plan
- **Reset:** assert i_reset for 2 cycles with both requesters valid → readies 0 and `o_rsp_valid`=0 throughout. In the first cycle after release with both valid, requester 0 is granted.
- **SLL by 31:** req0 only, op_a=0x0000_0001, op_b=0x1F, op=00, tag=3, rsp_ready=1 → next cycle `o_rsp_data`=0x8000_0000, id=0, tag=3, valid=1.
- **SRA with ignored high bits:** req1 only, op_a=0x8000_0000, op_b=0x0000_0024, op=10 → `o_rsp_data`=0xF800_0000, id=1. Same inputs with op=01 → 0x0800_0000. Same inputs with op=11 → 0x0000_0000.
- **Contention:** both requesters valid for 6 cycles, rsp_ready=1 → grants alternate 0,1,0,1,0,1, with one response per cycle in matching id order.
- **Backpressure:** response pending, rsp_ready=0 for 3 cycles → both readies 0 and `o_rsp_*` unchanged. On the cycle rsp_ready=1, the old response drains and a valid request is accepted in the same edge, so `o_rsp_valid` stays 1.
- **Reset mid-operation:** `o_rsp_valid`=1 and rr=1, assert i_reset for one cycle → `o_rsp_valid`=0 and `o_rsp_data`=0. The next contention grants requester 0.
